// File: rtl/alu_seq_pkg.sv
// Shared types, strobe constants and opcode helpers for the ALU control sequencer.
package alu_seq_pkg;

   localparam int unsigned NUM_STROBES = 5;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_LOAD = 2'b01,
      OP_ADDI = 2'b10,
      OP_MAC  = 2'b11
   } op_t;

   // Strobe states are contiguous so S_A..S_E map to mask bits 0..4.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      S_A    = 3'd1,
      S_B    = 3'd2,
      S_C    = 3'd3,
      S_D    = 3'd4,
      S_E    = 3'd5,
      SETTLE = 3'd6,
      DONE   = 3'd7
   } state_t;

   localparam logic [NUM_STROBES-1:0] REN_A = 5'b00001;
   localparam logic [NUM_STROBES-1:0] REN_B = 5'b00010;
   localparam logic [NUM_STROBES-1:0] REN_C = 5'b00100;
   localparam logic [NUM_STROBES-1:0] REN_D = 5'b01000;
   localparam logic [NUM_STROBES-1:0] REN_E = 5'b10000;

   function automatic logic [NUM_STROBES-1:0] op_mask(input op_t op);
      case (op)
         OP_LOAD: return REN_E;
         OP_ADDI: return REN_E;
         OP_MAC:  return REN_A | REN_B | REN_C | REN_D | REN_E;
         default: return '0;
      endcase
   endfunction

   function automatic logic [NUM_STROBES-1:0] state_strobe(input state_t s);
      case (s)
         S_A:     return REN_A;
         S_B:     return REN_B;
         S_C:     return REN_C;
         S_D:     return REN_D;
         S_E:     return REN_E;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/alu_seq_step.sv
// Finds the next strobe state after cur_state whose mask bit is set, or SETTLE if none.
module alu_seq_step
   import alu_seq_pkg::*;
(
   input  state_t                 cur_state,
   input  logic [NUM_STROBES-1:0] mask,
   output state_t                 next_state
);

   int first;

   always_comb begin
      next_state = SETTLE;
      first      = 0;
      case (cur_state)
         IDLE:    first = 0;
         S_A:     first = 1;
         S_B:     first = 2;
         S_C:     first = 3;
         S_D:     first = 4;
         default: first = int'(NUM_STROBES);
      endcase
      // Scan downwards so the lowest eligible bit wins.
      for (int i = int'(NUM_STROBES) - 1; i >= 0; i--) begin
         if (i >= first && mask[i]) begin
            next_state = state_t'(3'(i + 1));
         end
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Accepts one ALU instruction, walks the one-hot strobe sequence, captures the
// ALU result and hands it to writeback over a valid/ready handshake.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned BUS_WIDTH = 8,
   parameter int unsigned CNT_WIDTH = 8
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             in_op,
   input  logic [BUS_WIDTH-1:0]   in_imm,
   output logic [BUS_WIDTH-1:0]   alu_imm,
   output logic [NUM_STROBES-1:0] alu_reg_en,
   output logic                   alu_f_add,
   output logic                   alu_f_load,
   input  logic [BUS_WIDTH-1:0]   alu_result,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [BUS_WIDTH-1:0]   out_data,
   output logic [CNT_WIDTH-1:0]   retired
);

   state_t                 state;
   state_t                 step_next;
   op_t                    new_op;
   logic [NUM_STROBES-1:0] mask_q;
   logic [NUM_STROBES-1:0] step_mask;

   assign new_op    = op_t'(in_op);
   // In IDLE the first strobe is chosen from the incoming opcode.
   assign step_mask = (state == IDLE) ? op_mask(new_op) : mask_q;

   alu_seq_step u_step (
      .cur_state  (state),
      .mask       (step_mask),
      .next_state (step_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         mask_q     <= '0;
         alu_imm    <= '0;
         alu_reg_en <= '0;
         alu_f_add  <= 1'b0;
         alu_f_load <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         retired    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready   <= 1'b0;
                  alu_imm    <= in_imm;
                  alu_f_load <= (new_op == OP_LOAD);
                  alu_f_add  <= (new_op == OP_ADDI);
                  mask_q     <= op_mask(new_op);
                  if (new_op == OP_NOP) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                  end else begin
                     state      <= step_next;
                     alu_reg_en <= state_strobe(step_next);
                  end
               end
            end
            S_A, S_B, S_C, S_D, S_E: begin
               state      <= step_next;
               alu_reg_en <= state_strobe(step_next);
            end
            SETTLE: begin
               state     <= DONE;
               out_data  <= alu_result;
               out_valid <= 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  retired   <= retired + CNT_WIDTH'(1);
               end
            end
            default: begin
               state      <= IDLE;
               in_ready   <= 1'b1;
               alu_reg_en <= '0;
               out_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: latency-based reference model checked every cycle,
// plus hand-computed literal expectations.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [1:0] in_op = 2'b00;
   logic [7:0] in_imm = 8'h00;
   logic [7:0] alu_imm;
   logic [4:0] alu_reg_en;
   logic       alu_f_add;
   logic       alu_f_load;
   logic [7:0] alu_result = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic [7:0] retired;

   int errors = 0;
   int checks = 0;
   logic chk_en = 1'b0;
   logic hold_res = 1'b0;
   logic [7:0] fixed_res = 8'h2A;

   // Reference model state: instruction age and latency rather than FSM states.
   logic       m_busy = 1'b0;
   logic       m_ov = 1'b0;
   int         m_k = 0;
   int         m_lat = 0;
   logic [1:0] m_op = 2'b00;
   logic [7:0] m_imm = 8'h00;
   logic       m_fl = 1'b0;
   logic       m_fa = 1'b0;
   logic [7:0] m_data = 8'h00;
   logic [7:0] m_ret = 8'h00;

   alu_sequencer #(.BUS_WIDTH(8), .CNT_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_imm     (in_imm),
      .alu_imm    (alu_imm),
      .alu_reg_en (alu_reg_en),
      .alu_f_add  (alu_f_add),
      .alu_f_load (alu_f_load),
      .alu_result (alu_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   // ALU stand-in: result changes every cycle unless pinned, so capture timing matters.
   always begin
      @(posedge clk);
      #2;
      alu_result = hold_res ? fixed_res : alu_result + 8'h13;
   end

   always begin
      @(posedge clk);
      if (rst) begin
         m_busy = 1'b0; m_ov = 1'b0; m_k = 0;
         m_imm = 8'h00; m_fl = 1'b0; m_fa = 1'b0;
         m_data = 8'h00; m_ret = 8'h00;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy = 1'b1;
            m_op   = in_op;
            m_k    = 1;
            m_imm  = in_imm;
            m_fl   = (in_op == 2'b01);
            m_fa   = (in_op == 2'b10);
            m_lat  = (in_op == 2'b00) ? 1 : (in_op == 2'b11) ? 7 : 3;
            if (m_lat == 1) m_ov = 1'b1;
         end
      end else if (m_ov) begin
         if (out_ready) begin
            m_busy = 1'b0;
            m_ov   = 1'b0;
            m_ret  = m_ret + 8'd1;
         end
      end else begin
         m_k = m_k + 1;
         if (m_k == m_lat) begin
            m_ov   = 1'b1;
            m_data = alu_result;
         end
      end
   end

   function automatic logic [4:0] exp_ren();
      logic [4:0] one;
      one = 5'b00001;
      if (!m_busy || m_ov) return 5'b00000;
      if (m_op == 2'b11 && m_k >= 1 && m_k <= 5) return one << (m_k - 1);
      if ((m_op == 2'b01 || m_op == 2'b10) && m_k == 1) return 5'b10000;
      return 5'b00000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   always begin
      @(negedge clk);
      if (chk_en) begin
         chk("model in_ready",   32'(in_ready),   32'(!m_busy));
         chk("model alu_imm",    32'(alu_imm),    32'(m_imm));
         chk("model alu_reg_en", 32'(alu_reg_en), 32'(exp_ren()));
         chk("model alu_f_add",  32'(alu_f_add),  32'(m_fa));
         chk("model alu_f_load", 32'(alu_f_load), 32'(m_fl));
         chk("model out_valid",  32'(out_valid),  32'(m_ov));
         chk("model out_data",   32'(out_data),   32'(m_data));
         chk("model retired",    32'(retired),    32'(m_ret));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Wait for out_valid with a cycle budget, then complete the handshake.
   task automatic finish_op(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      chk({name, " done within budget"}, 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      tick();
   endtask

   task automatic run_op(input logic [1:0] op, input logic [7:0] imm, input string name);
      in_valid = 1'b1; in_op = op; in_imm = imm;
      tick();
      in_valid = 1'b0;
      finish_op(name);
   endtask

   initial begin
      // Reset and idle
      tick(); tick();
      rst = 1'b0;
      chk_en = 1'b1;
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset reg_en", 32'(alu_reg_en), 32'd0);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset retired", 32'(retired), 32'd0);
      repeat (10) tick();
      chk("idle reg_en", 32'(alu_reg_en), 32'd0);

      // Reset at t0+3 of a MAC
      in_valid = 1'b1; in_op = 2'b11; in_imm = 8'h44;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midreset reg_en", 32'(alu_reg_en), 32'd0);
      chk("midreset alu_imm", 32'(alu_imm), 32'd0);
      chk("midreset out_data", 32'(out_data), 32'd0);
      chk("midreset retired", 32'(retired), 32'd0);
      chk("midreset in_ready", 32'(in_ready), 32'd1);
      tick();

      // LOAD with ALU pinned at 0x2A
      hold_res = 1'b1;
      in_valid = 1'b1; in_op = 2'b01; in_imm = 8'h05;
      tick();
      in_valid = 1'b0;
      chk("load t0+1 reg_en", 32'(alu_reg_en), 32'h10);
      chk("load f_load", 32'(alu_f_load), 32'd1);
      tick();
      chk("load t0+2 reg_en", 32'(alu_reg_en), 32'd0);
      chk("load t0+2 out_valid", 32'(out_valid), 32'd0);
      tick();
      chk("load t0+3 out_valid", 32'(out_valid), 32'd1);
      chk("load out_data", 32'(out_data), 32'h2A);
      tick();
      chk("load retired", 32'(retired), 32'd1);
      hold_res = 1'b0;

      // MAC strobe walk
      in_valid = 1'b1; in_op = 2'b11; in_imm = 8'h03;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         logic [4:0] one;
         one = 5'b00001;
         chk("mac strobe", 32'(alu_reg_en), 32'(one << (k - 1)));
         chk("mac alu_imm", 32'(alu_imm), 32'h03);
         tick();
      end
      chk("mac t0+6 out_valid", 32'(out_valid), 32'd0);
      tick();
      chk("mac t0+7 out_valid", 32'(out_valid), 32'd1);
      tick();

      run_op(2'b10, 8'h7E, "addi");

      // Backpressure with a pending second instruction
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 2'b11; in_imm = 8'h11;
      tick();
      in_op = 2'b10; in_imm = 8'h22;
      repeat (6) tick();
      chk("bp done out_valid", 32'(out_valid), 32'd1);
      repeat (5) tick();
      chk("bp stall in_ready", 32'(in_ready), 32'd0);
      chk("bp stall alu_imm", 32'(alu_imm), 32'h11);
      out_ready = 1'b1;
      tick();
      chk("bp idle in_ready", 32'(in_ready), 32'd1);
      chk("bp idle out_valid", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      chk("bp second alu_imm", 32'(alu_imm), 32'h22);
      chk("bp second f_add", 32'(alu_f_add), 32'd1);
      finish_op("bp second");
      chk("bp retired", 32'(retired), 32'd5);

      // Counter wrap via NOPs
      for (int i = 0; i < 251; i++) run_op(2'b00, 8'(i), "nop");
      chk("wrap retired zero", 32'(retired), 32'd0);
      for (int i = 0; i < 5; i++) run_op(2'b00, 8'hFF, "nop");
      chk("wrap retired five", 32'(retired), 32'd5);

      tick();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
